// File: rtl/hex_display_pkg.sv
// hex_display_pkg
// Shared definitions for the seven-segment display bank: register word
// addresses, CTRL bit positions and the active-high hex segment table.
// No ports; imported by hex_display_bank and hex_seg_decode.
package hex_display_pkg;

  localparam logic [3:0] ADDR_DIGIT0 = 4'd0;
  localparam logic [3:0] ADDR_CTRL   = 4'd8;
  localparam logic [3:0] ADDR_DECODE = 4'd9;
  localparam logic [3:0] ADDR_BLINK  = 4'd10;
  localparam logic [3:0] ADDR_STATUS = 4'd11;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_BLINK_EN = 1;
  localparam int CTRL_RESTART  = 2;

  // Segment order is {g,f,e,d,c,b,a}, 1 = lit; letters appear as A b C d E F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_display_bank_seg_decode.sv
// hex_seg_decode
// Combinational nibble to seven-segment converter, active-high output.
// Ports:
//   nibble : in  [3:0] hex value
//   seg    : out [6:0] segments {g,f,e,d,c,b,a}, 1 = lit
module hex_seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/hex_display_bank.sv
// hex_display_bank
// Avalon-MM slave driving up to eight seven-segment digits (plus dp) from a
// small register file, with optional per-digit hex decoding, per-digit
// blinking from a free-running divider, a global enable and selectable
// segment polarity.
// Optional feature macro: HEX_DISPLAY_DECODE_EN (adds the hex decoders and
// the DECODE_MASK register; without it every digit is raw).
// Ports:
//   clk        : in  system clock
//   reset      : in  synchronous active-high reset
//   address    : in  [3:0] word address
//   chipselect : in  slave select
//   write_n    : in  active-low write strobe
//   writedata  : in  [31:0] write data
//   readdata   : out [31:0] combinational read data, unmapped bits 0
//   out_port   : out [8*NUM_DIGITS-1:0] registered segment outputs,
//                digit i in bits [8i+7:8i], bit 7 = dp
module hex_display_bank
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int BLINK_DIV      = 25000000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [8*NUM_DIGITS-1:0] out_port
);

  localparam int CNT_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
  // XOR mask that both inverts for active-low pins and is the blank value.
  localparam logic [7:0] BLANK = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [7:0]            digit_reg [NUM_DIGITS];
  logic                  ctrl_en;
  logic                  ctrl_blink_en;
  logic [NUM_DIGITS-1:0] blink_mask;
  logic [CNT_W-1:0]      blink_cnt;
  logic                  phase;
  logic [8*NUM_DIGITS-1:0] pattern_next;

  logic wr;
  logic restart_wr;
  logic unused_wdata;

  assign wr         = chipselect && !write_n;
  assign restart_wr = wr && (address == ADDR_CTRL) && writedata[CTRL_RESTART];
  assign unused_wdata = ^writedata;

`ifdef HEX_DISPLAY_DECODE_EN
  logic [NUM_DIGITS-1:0] decode_mask;
  logic [6:0]            dec_seg [NUM_DIGITS];

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
    hex_seg_decode u_dec (
      .nibble (digit_reg[gi][3:0]),
      .seg    (dec_seg[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (reset)
      decode_mask <= '0;
    else if (wr && address == ADDR_DECODE)
      decode_mask <= writedata[NUM_DIGITS-1:0];
  end
`endif

  // Register file: digits, CTRL enables and blink mask. RESTART is not
  // stored; it only acts on the divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_reg[i] <= '0;
      ctrl_en       <= 1'b0;
      ctrl_blink_en <= 1'b0;
      blink_mask    <= '0;
    end else if (wr) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (address == 4'(i)) digit_reg[i] <= writedata[7:0];
      if (address == ADDR_CTRL) begin
        ctrl_en       <= writedata[CTRL_EN];
        ctrl_blink_en <= writedata[CTRL_BLINK_EN];
      end
      if (address == ADDR_BLINK)
        blink_mask <= writedata[NUM_DIGITS-1:0];
    end
  end

  // Blink divider: a restart write beats a simultaneous wrap, and a
  // disabled divider sits at count 0 / phase 0.
  always_ff @(posedge clk) begin
    if (reset || restart_wr || !ctrl_blink_en) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == CNT_MAX) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Per-digit lit pattern, then polarity applied by XOR with the blank code.
  always_comb begin
    logic [7:0] lit;
    pattern_next = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lit = digit_reg[i];
`ifdef HEX_DISPLAY_DECODE_EN
      if (decode_mask[i]) lit = {digit_reg[i][7], dec_seg[i]};
`endif
      if (!ctrl_en || (ctrl_blink_en && blink_mask[i] && phase)) lit = 8'h00;
      pattern_next[8*i +: 8] = lit ^ BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      out_port <= {NUM_DIGITS{BLANK}};
    else
      out_port <= pattern_next;
  end

  // Zero-wait-state read mux straight from the registers.
  always_comb begin
    readdata = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (address == 4'(i)) readdata = {24'h0, digit_reg[i]};
    case (address)
      ADDR_CTRL:   readdata = {30'h0, ctrl_blink_en, ctrl_en};
`ifdef HEX_DISPLAY_DECODE_EN
      ADDR_DECODE: readdata = 32'(decode_mask);
`endif
      ADDR_BLINK:  readdata = 32'(blink_mask);
      ADDR_STATUS: readdata = {31'h0, phase};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hex_display_bank.sv
// tb_hex_display_bank
// Self-checking bench for hex_display_bank (NUM_DIGITS=8, BLINK_DIV=4,
// active-low segments). Follows HEX_DISPLAY_DECODE_EN the same way the RTL
// does. Expected values come from a behavioural model of the register file
// and blink timing.
module tb_hex_display_bank;

  localparam int ND  = 8;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [63:0] out_port;

  int total = 0;
  int bad   = 0;

  hex_display_bank #(.NUM_DIGITS(ND), .BLINK_DIV(DIV), .SEG_ACTIVE_LOW(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  // Model state: registers plus the number of enabled divider cycles since
  // the last restart; phase follows from that count directly.
  logic [7:0] m_digit [ND];
  logic       m_en, m_ben;
  logic [7:0] m_dec, m_bmask;
  int         m_ticks;

  logic [6:0] tb_seg [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic m_phase();
    return ((m_ticks / DIV) % 2) == 1;
  endfunction

  function automatic logic [63:0] model_out();
    logic [63:0] r;
    logic [7:0]  lit;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      lit = m_digit[i];
`ifdef HEX_DISPLAY_DECODE_EN
      if (m_dec[i]) lit = {m_digit[i][7], tb_seg[m_digit[i][3:0]]};
`endif
      if (!m_en || (m_ben && m_bmask[i] && m_phase())) lit = 8'h00;
      r[8*i +: 8] = ~lit;
    end
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input int a);
    if (a < ND) return 32'(m_digit[a]);
    case (a)
      8:  return {30'h0, m_ben, m_en};
`ifdef HEX_DISPLAY_DECODE_EN
      9:  return 32'(m_dec);
`endif
      10: return 32'(m_bmask);
      11: return {31'h0, m_phase()};
      default: return 32'h0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge with optional write and reset, model updated in step,
  // then out_port compared a little after the edge.
  task automatic applyStimulus(input logic do_wr, input int a, input logic [31:0] d, input logic rst);
    logic [63:0] exp_out;
    reset      = rst;
    address    = 4'(a);
    chipselect = do_wr;
    write_n    = !do_wr;
    writedata  = d;
    exp_out    = model_out();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < ND; i++) m_digit[i] = '0;
      m_en = 0; m_ben = 0; m_dec = '0; m_bmask = '0; m_ticks = 0;
      exp_out = '1;
    end else begin
      if (do_wr && a == 8 && d[2]) m_ticks = 0;
      else if (m_ben)              m_ticks++;
      else                         m_ticks = 0;
      if (do_wr) begin
        if (a < ND) m_digit[a] = d[7:0];
        else if (a == 8) begin m_en = d[0]; m_ben = d[1]; end
`ifdef HEX_DISPLAY_DECODE_EN
        else if (a == 9) m_dec = d[7:0];
`endif
        else if (a == 10) m_bmask = d[7:0];
      end
    end
    #1;
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    checkOutput("out_port", out_port, exp_out);
  endtask

  task automatic checkRead(input int a);
    address = 4'(a);
    #1;
    checkOutput($sformatf("readdata[%0d]", a), {32'h0, readdata}, {32'h0, model_rd(a)});
  endtask

  initial begin
    int guard;
    int a;
    logic [31:0] d;

    // Reset, nothing written: everything blank and every register reads 0.
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("reset_blank", out_port, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 16; i++) checkRead(i);

    // Raw digit 2 with global enable.
    applyStimulus(1, 8, 32'h1, 0);
    applyStimulus(1, 2, 32'h3F, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("digit2_raw", out_port, 64'hFFFF_FFFF_FFC0_FFFF);
    checkRead(2);

`ifdef HEX_DISPLAY_DECODE_EN
    // Decoded 'A' with dp on digit 0.
    applyStimulus(1, 9, 32'h01, 0);
    applyStimulus(1, 0, 32'h8A, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("digit0_decoded", {56'h0, out_port[7:0]}, 64'h08);
`endif

    // Blink digit 2, then restart mid-period.
    applyStimulus(1, 10, 32'h04, 0);
    applyStimulus(1, 8, 32'h3, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkRead(11);
    end
    applyStimulus(1, 8, 32'h7, 0);
    checkRead(11);
    checkOutput("status_after_restart", {32'h0, readdata}, 64'h0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkRead(11);
    end

    // Reserved and decode-mask writes.
    applyStimulus(1, 12, 32'hFFFF_FFFF, 0);
    checkRead(12);
    applyStimulus(1, 9, 32'h0000_00A5, 0);
    checkRead(9);
    checkRead(8);

    // Reset while the blinking digit is in its dark phase.
    guard = 0;
    while (!m_phase() && guard < 20) begin
      applyStimulus(0, 0, 0, 0);
      guard++;
    end
    checkOutput("reach_phase1", {63'h0, m_phase()}, 64'h1);
    checkRead(11);
    applyStimulus(0, 0, 0, 1);
    checkOutput("reset_midblink", out_port, 64'hFFFF_FFFF_FFFF_FFFF);
    checkRead(11);
    checkOutput("status_after_reset", {32'h0, readdata}, 64'h0);

    // Randomized register traffic against the model.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0: begin a = 8; d = 32'($urandom_range(0, 3)) | (($urandom_range(0, 7) == 0) ? 32'h4 : 32'h0);
                 if ($urandom_range(0, 3) != 0) d[0] = 1'b1; end
        1: begin a = $urandom_range(9, 15); d = $urandom; end
        2, 3: begin a = $urandom_range(0, 7); d = $urandom; end
        default: begin a = -1; d = '0; end
      endcase
      if (a < 0) applyStimulus(0, 0, 0, 0);
      else       applyStimulus(1, a, d, 0);
      checkRead($urandom_range(0, 15));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
